// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles the fetch port, data port and memory port of mem_port_arbiter.
// Latency : n/a (signal bundle only).
// Backpressure: requesters hold req and request fields stable until the matching gnt.
//
// Ports (arbiter view, modport slave):
//   fetch : if_req, if_addr, if_flush  -> if_gnt, if_valid, if_rdata
//   data  : dm_req, dm_we, dm_addr, dm_wdata -> dm_gnt, dm_valid, dm_rdata
//   memory: mem_ce, mem_we, mem_addr, mem_wdata -> mem_rdata (combinational read)
// The master modport is the mirror image, used by whatever drives the requests
// and models the memory.

interface mem_port_arbiter_if;

  // fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;

  // data requester
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_valid;
  logic [31:0] dm_rdata;

  // shared memory port
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_valid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_valid, dm_rdata,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_valid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_valid, dm_rdata,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one combinational-read memory port between instruction fetch and data access.
// Latency : gnt in cycle N, memory access in N+1, registered *_valid/*_rdata in N+2; one transaction per cycle.
// Backpressure: data side has fixed priority; a losing requester keeps req high until its gnt.
//
// Ports:
//   clk   - single clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - mem_port_arbiter_if.slave: fetch port, data port and memory port
// Optional feature: define ARB_STARVE_GUARD_EN to let fetch win after STARVE_MAX
// consecutive data grants that blocked it (STARVE_MAX legal range 1..15).
// Without it data has strict priority and fetch can wait indefinitely.

module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } src_t;

  // Transaction sitting in the ACCESS stage.
  typedef struct packed {
    logic        vld;
    src_t        src;
    logic        we;
    logic        kill;   // fetch granted while flush was high: access runs, no response
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        acc_q;
  logic        if_win;
  logic        dm_win;
  logic        force_if;
  logic        fetch_ret;
  logic        data_ret;
  logic        if_valid_q;
  logic        dm_valid_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign force_if = bus.if_req && (starve_cnt == 4'(STARVE_MAX));

  // Counts consecutive cycles where fetch was waiting and data took the port.
  // It cannot pass STARVE_MAX: reaching it forces a fetch grant, which clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!bus.if_req || if_win) begin
      starve_cnt <= 4'd0;
    end else if (dm_win) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // ARB stage
  // ---------------------------------------------------------------------------
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (rst_n) begin
      if (force_if) begin
        if_win = 1'b1;
      end else if (bus.dm_req) begin
        dm_win = 1'b1;
      end else if (bus.if_req) begin
        if_win = 1'b1;
      end
    end
  end

  assign bus.if_gnt = if_win;
  assign bus.dm_gnt = dm_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q.vld <= if_win | dm_win;
      if (dm_win) begin
        acc_q.src   <= SRC_DM;
        acc_q.we    <= bus.dm_we;
        acc_q.kill  <= 1'b0;
        acc_q.addr  <= bus.dm_addr;
        acc_q.wdata <= bus.dm_wdata;
      end else if (if_win) begin
        acc_q.src   <= SRC_IF;
        acc_q.we    <= 1'b0;
        acc_q.kill  <= bus.if_flush;
        acc_q.addr  <= bus.if_addr;
        acc_q.wdata <= 32'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ACCESS stage: drive the memory port from the registered transaction.
  // Enables are gated with rst_n so a write caught by reset never commits.
  // ---------------------------------------------------------------------------
  assign bus.mem_ce    = rst_n & acc_q.vld;
  assign bus.mem_we    = rst_n & acc_q.vld & acc_q.we;
  assign bus.mem_addr  = acc_q.vld ? acc_q.addr : 32'd0;
  assign bus.mem_wdata = (acc_q.vld && acc_q.we) ? acc_q.wdata : 32'd0;

  // ---------------------------------------------------------------------------
  // RESP stage
  // ---------------------------------------------------------------------------
  // A flush seen during the fetch's ACCESS cycle drops its response.
  assign fetch_ret = acc_q.vld && (acc_q.src == SRC_IF) && !acc_q.kill && !bus.if_flush;
  assign data_ret  = acc_q.vld && (acc_q.src == SRC_DM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      if_valid_q <= fetch_ret;
      dm_valid_q <= data_ret;
      if (fetch_ret) begin
        if_rdata_q <= bus.mem_rdata;
      end
      // Writes only acknowledge; read data keeps its last value.
      if (data_ret && !acc_q.we) begin
        dm_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // A flush in the response cycle also hides a fetch response already registered.
  assign bus.if_valid = if_valid_q & ~bus.if_flush;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_valid = dm_valid_q;
  assign bus.dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter with a word-array memory model.
// Latency : inputs change 1 time unit after each rising edge, outputs are checked 1 unit later.
// Backpressure: requesters in this bench hold req until granted.

module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] mem [0:1023];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write commits on the rising edge.
  assign bus.mem_rdata = bus.mem_ce ? mem[bus.mem_addr[11:2]] : 32'd0;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start a new cycle: step past the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h8F99_0000 | (i * 4);

    rst_n        = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h4;
    bus.if_flush = 1'b0;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h20;
    bus.dm_wdata = 32'h0;

    // ---------------- reset held 3 cycles with both requests high
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rst_ctl", {26'd0, bus.if_gnt, bus.dm_gnt, bus.mem_ce, bus.mem_we, bus.if_valid, bus.dm_valid}, 32'd0);
    end
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'd0);

    cyc(); rst_n = 1'b1; #1;
    chk("rel_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'd1);
    cyc(); bus.if_req = 1'b0; bus.dm_req = 1'b0; #1;
    chk("rel_ce", {31'd0, bus.mem_ce}, 32'd1);
    chk("rel_addr", bus.mem_addr, 32'h20);
    cyc(); #1;
    chk("rel_dm_valid", {31'd0, bus.dm_valid}, 32'd1);
    chk("rel_dm_rdata", bus.dm_rdata, 32'h8F990020);

    // ---------------- single fetch
    cyc(); bus.if_req = 1'b1; bus.if_addr = 32'h8; #1;
    chk("sf_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'd2);
    cyc(); bus.if_req = 1'b0; #1;
    chk("sf_ce", {30'd0, bus.mem_ce, bus.mem_we}, 32'd2);
    chk("sf_addr", bus.mem_addr, 32'h8);
    chk("sf_early_valid", {31'd0, bus.if_valid}, 32'd0);
    cyc(); #1;
    chk("sf_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("sf_rdata", bus.if_rdata, 32'h8F990008);
    cyc(); #1;
    chk("sf_pulse", {31'd0, bus.if_valid}, 32'd0);
    chk("sf_hold", bus.if_rdata, 32'h8F990008);

    // ---------------- contention
    cyc(); bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10; #1;
    chk("ct_gnt0", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'd1);
    cyc(); bus.dm_req = 1'b0; #1;
    chk("ct_gnt1", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'd2);
    chk("ct_addr1", bus.mem_addr, 32'h10);
    cyc(); bus.if_req = 1'b0; #1;
    chk("ct_v2", {30'd0, bus.if_valid, bus.dm_valid}, 32'd1);
    chk("ct_dm_rdata", bus.dm_rdata, 32'h8F990010);
    chk("ct_addr2", bus.mem_addr, 32'h0);
    cyc(); #1;
    chk("ct_v3", {30'd0, bus.if_valid, bus.dm_valid}, 32'd2);
    chk("ct_if_rdata", bus.if_rdata, 32'h8F990000);

    // ---------------- write then read same address
    cyc(); bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'hFF8; bus.dm_wdata = 32'hAAAAAAAA; #1;
    chk("wr_gnt", {31'd0, bus.dm_gnt}, 32'd1);
    cyc(); bus.dm_we = 1'b0; bus.dm_wdata = 32'h0; #1;
    chk("rd_gnt", {31'd0, bus.dm_gnt}, 32'd1);
    chk("wr_port", {30'd0, bus.mem_ce, bus.mem_we}, 32'd3);
    chk("wr_wdata", bus.mem_wdata, 32'hAAAAAAAA);
    chk("wr_addr", bus.mem_addr, 32'hFF8);
    cyc(); bus.dm_req = 1'b0; #1;
    chk("wr_ack", {31'd0, bus.dm_valid}, 32'd1);
    chk("wr_rdata_hold", bus.dm_rdata, 32'h8F990010);
    chk("rd_port", {30'd0, bus.mem_ce, bus.mem_we}, 32'd2);
    cyc(); #1;
    chk("rd_valid", {31'd0, bus.dm_valid}, 32'd1);
    chk("rd_rdata", bus.dm_rdata, 32'hAAAAAAAA);

    // ---------------- flush of fetches granted in N and N+1
    cyc(); bus.if_req = 1'b1; bus.if_addr = 32'h4; #1;
    chk("fl_gnt0", {31'd0, bus.if_gnt}, 32'd1);
    cyc(); bus.if_addr = 32'hC; bus.if_flush = 1'b1; #1;
    chk("fl_gnt1", {31'd0, bus.if_gnt}, 32'd1);
    cyc(); bus.if_addr = 32'h14; bus.if_flush = 1'b0; #1;
    chk("fl_gnt2", {31'd0, bus.if_gnt}, 32'd1);
    chk("fl_v2", {31'd0, bus.if_valid}, 32'd0);
    cyc(); bus.if_req = 1'b0; #1;
    chk("fl_v3", {31'd0, bus.if_valid}, 32'd0);
    cyc(); #1;
    chk("fl_v4", {31'd0, bus.if_valid}, 32'd1);
    chk("fl_rdata", bus.if_rdata, 32'h8F990014);

    // ---------------- flush in the response cycle masks if_valid
    cyc(); bus.if_req = 1'b1; bus.if_addr = 32'h18; #1;
    chk("fm_gnt", {31'd0, bus.if_gnt}, 32'd1);
    cyc(); bus.if_req = 1'b0; #1;
    cyc(); bus.if_flush = 1'b1; #1;
    chk("fm_mask", {31'd0, bus.if_valid}, 32'd0);
    cyc(); bus.if_flush = 1'b0; #1;
    chk("fm_after", {31'd0, bus.if_valid}, 32'd0);

    // ---------------- reset during a write's ACCESS cycle
    cyc(); bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h12345678; #1;
    chk("rw_gnt", {31'd0, bus.dm_gnt}, 32'd1);
    cyc(); bus.dm_req = 1'b0; bus.dm_we = 1'b0; rst_n = 1'b0; #1;
    chk("rw_port", {30'd0, bus.mem_ce, bus.mem_we}, 32'd0);
    cyc(); rst_n = 1'b1; bus.dm_req = 1'b1; bus.dm_addr = 32'h40; #1;
    chk("rw_novalid", {31'd0, bus.dm_valid}, 32'd0);
    chk("rw_rdata_clr", bus.dm_rdata, 32'd0);
    chk("rw_rd_gnt", {31'd0, bus.dm_gnt}, 32'd1);
    cyc(); bus.dm_req = 1'b0; #1;
    cyc(); #1;
    chk("rw_rd_valid", {31'd0, bus.dm_valid}, 32'd1);
    chk("rw_rd_data", bus.dm_rdata, 32'h8F990040);

    // ---------------- starvation: both requests held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      logic [31:0] exp;
      cyc();
      bus.if_req = 1'b1; bus.if_addr = 32'h0;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0;
      #1;
`ifdef ARB_STARVE_GUARD_EN
      exp = (i == 4 || i == 9) ? 32'd2 : 32'd1;
`else
      exp = 32'd1;
`endif
      chk($sformatf("starve_c%0d", i), {30'd0, bus.if_gnt, bus.dm_gnt}, exp);
    end
    cyc(); bus.if_req = 1'b0; bus.dm_req = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    chk("idle_ce", {31'd0, bus.mem_ce}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-ported, combinational-read CPU memory between the instruction-fetch stage and the data-memory stage. It accepts one request per cycle, drives the memory port in the following cycle, and returns registered read data one cycle later. Sits between the IF/MEM pipeline stages and the unified instruction/data memory. It provides fixed data-side priority, an optional starvation guard for fetch, and in-flight fetch squash on pipeline flush.

## Interface
- `STARVE_MAX`, 4: consecutive fetch-blocking data grants tolerated before fetch is forced; used only with the guard compiled in; legal range 1–15.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch request, level.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: combinational; fetch request accepted this cycle.
- `if_valid` out 1: registered; fetch data valid, one-cycle pulse.
- `if_rdata` out 32: registered fetch data.
- `if_flush` in 1: squash all accepted-but-unreturned fetches.
- `dm_req` in 1: data request, level.
- `dm_we` in 1: 1 = write, 0 = read.
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: write data.
- `dm_gnt` out 1: combinational; data request accepted this cycle.
- `dm_valid` out 1: registered; read data or write acknowledge, one-cycle pulse.
- `dm_rdata` out 32: registered read data.
- `mem_ce` out 1: memory chip enable.
- `mem_we` out 1: memory write enable; memory commits on the rising edge ending the cycle.
- `mem_addr` out 32: memory byte address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, combinational from `mem_ce`/`mem_addr`.

## Operation
- Pipeline stages: ARB (cycle N), ACCESS (N+1), RESP (N+2).
- ARB: while `rst_n`=1, the winner is `dm` if `dm_req`=1, else `if` if `if_req`=1. The guard override is described under Configuration. The winner's `*_gnt` is 1. At most one `gnt` is high per cycle. No `gnt` is issued while `rst_n`=0.
- Grant edge: register `acc_vld`=1, `acc_src` (IF/DM), `acc_addr`, `acc_we` (0 for fetch), `acc_wdata`. No grant gives `acc_vld`=0.
- ACCESS: when `acc_vld`=1, `mem_ce`=1 and `mem_addr`=`acc_addr`. For a data write, `mem_we`=1 and `mem_wdata`=`acc_wdata`. When `acc_vld`=0, `mem_ce`, `mem_we`, `mem_addr` and `mem_wdata` are all 0.
- `mem_ce` and `mem_we` are ANDed with `rst_n`, so no memory access occurs in any cycle with `rst_n`=0.
- Edge ending ACCESS:
  - Fetch: `if_rdata` <= `mem_rdata` and `if_valid` <= 1.
  - Data read: `dm_rdata` <= `mem_rdata` and `dm_valid` <= 1.
  - Data write: `dm_valid` <= 1 and `dm_rdata` holds its value.
- `*_rdata` holds its last value between pulses.
- Flush: `if_flush`=1 in cycle C clears the fetch response for any fetch in ACCESS during C. It also clears `if_valid` if high in C; `if_valid` is forced 0 in any cycle `if_flush`=1. A fetch granted in C itself is also squashed: its ACCESS runs but produces no `if_valid`. Data transactions are never affected.
- Requesters hold `req` and the request fields stable until `gnt`, and may present the next request in the cycle after `gnt`.
- Addresses pass through unmodified; no alignment check.

## Timing
- Latency: `gnt` in N, memory access in N+1, `*_valid` in N+2. Throughput is one transaction per cycle for the port and for each requester.
- Write visibility: a read granted the cycle after a write to the same address returns the new data, because the write commits at the edge ending its ACCESS.
- Reset (`rst_n`=0 at an edge):
  - Outputs: `if_valid`, `dm_valid`, `if_rdata`, `dm_rdata` = 0.
  - Pipeline: `acc_vld`=0, `acc_*`=0.
  - Guard: starvation counter = 0.
  - Reset mid-operation drops every in-flight transaction with no `valid`. A write in ACCESS during a reset cycle does not commit, because `mem_we` is gated.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each cycle where `if_req`=1 and `dm` wins.
  - When the counter equals `STARVE_MAX` and `if_req`=1, `if` wins that cycle regardless of `dm_req`, and the counter clears.
  - The counter also clears on any `if_gnt` or any cycle with `if_req`=0.
- Undefined: strict data priority; no counter logic; fetch waits indefinitely.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with both `req`=1 → `gnt`, `mem_ce`, `mem_we`, `valid` all 0 throughout; first `dm_gnt` in the cycle after release.
- Single fetch: `if_req`, `if_addr`=0x8, memory returns 0x8F990008 → `if_gnt` in N, `mem_ce`=1 with `mem_addr`=0x8 in N+1, `if_valid`=1 with `if_rdata`=0x8F990008 in N+2.
- Contention: `if_req`(0x0) and `dm_req` read (0x10) held from cycle N → `dm_gnt` in N, `if_gnt` in N+1; `dm_valid` in N+2, `if_valid` in N+3.
- Write then read: write 0xAAAAAAAA to 0xFF8 in cycle N, read 0xFF8 in N+1 → `dm_valid` in N+2 (ack), `dm_valid` in N+3 with `dm_rdata`=0xAAAAAAAA.
- Flush: fetches granted in N and N+1, `if_flush`=1 in N+1 → no `if_valid` in N+2 or N+3; a fetch granted in N+2 returns `if_valid` in N+4.
- Starvation, `STARVE_MAX`=4, `dm_req` and `if_req` held high for 10 cycles:
  - With `ARB_STARVE_GUARD_EN` → `dm_gnt` in cycles 0–3, `if_gnt` in cycle 4, `dm_gnt` in cycles 5–8, `if_gnt` in cycle 9.
  - Without it → `if_gnt` never asserts.
